// File: rtl/sound_player_pkg.sv
// sound_player_pkg: sound codes shared with the animator and the player FSM states
package sound_player_pkg;
  localparam logic [1:0] SND_STOP = 2'b00;
  localparam logic [1:0] SND_PING = 2'b10;
  localparam logic [1:0] SND_PONG = 2'b01;
  localparam logic [1:0] SND_GO   = 2'b11;
  typedef enum logic [1:0] {IDLE, NOTE1, GAP, NOTE2} state_t;
endpackage

// File: rtl/sound_player_tone_divider.sv
// tone_divider: half-period counter and toggle flop producing the raw tone bit
module tone_divider #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             restart,
  input  logic [CNT_W-1:0] half,
  output logic             tone
);
  logic [CNT_W-1:0] cnt_q;
  logic             tone_q;
  logic             wrap;
  assign wrap = cnt_q == half - CNT_W'(1);
  assign tone = tone_q;
  // count to half-1 then wrap and toggle; restart forces phase 0
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else if (restart) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else if (wrap) begin
      cnt_q  <= '0;
      tone_q <= ~tone_q;
    end else begin
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/sound_player.sv
// sound_player: turns play strobes with a 2-bit sound code into timed square-wave tones
module sound_player
  import sound_player_pkg::*;
#(
  parameter int CNT_W     = 24,
  parameter int HALF_PING = 56818,
  parameter int HALF_PONG = 113636,
  parameter int HALF_GO   = 28409,
  parameter int DUR_CYC   = 5000000,
  parameter int GAP_CYC   = 1250000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       play,
  input  logic [1:0] code_sound,
  input  logic       mute,
  output logic       speaker,
  output logic       busy
);
  state_t           state_q, state_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] dur_q, dur_d, half;
  logic             tone, restart, last, speaker_d;
  assign last = state_q == GAP ? dur_q == CNT_W'(GAP_CYC - 1) : dur_q == CNT_W'(DUR_CYC - 1);
  // the divider is held at phase 0 outside notes and on every note boundary
  assign restart = play | last | state_q == IDLE | state_q == GAP;
  assign half = (state_q == NOTE2 || code_q == SND_PONG) ? CNT_W'(HALF_PONG)
              : code_q == SND_GO ? CNT_W'(HALF_GO) : CNT_W'(HALF_PING);
  // speaker drops together with busy, so a stop or note end leaves no trailing high
  assign speaker_d = ~restart & tone & ~mute;
  // next state: a play strobe always wins over note sequencing
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    dur_d   = dur_q + CNT_W'(1);
    if (play) begin
      dur_d = '0;
      if (code_sound == SND_STOP) state_d = IDLE;
      else begin
        state_d = NOTE1;
        code_d  = code_sound;
      end
    end else if (state_q == IDLE) begin
      dur_d = '0;
    end else if (last) begin
      dur_d   = '0;
      state_d = (state_q == NOTE1 && code_q == SND_GO) ? GAP : state_q == GAP ? NOTE2 : IDLE;
    end
  end
  // state, code latch, duration counter and registered outputs
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      code_q  <= SND_STOP;
      dur_q   <= '0;
      busy    <= 1'b0;
      speaker <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      dur_q   <= dur_d;
      busy    <= state_d != IDLE;
      speaker <= speaker_d;
    end
  end
  tone_divider #(.CNT_W(CNT_W)) u_div (
    .clk     (clk),
    .clr     (clr),
    .restart (restart),
    .half    (half),
    .tone    (tone)
  );
endmodule

// File: tb/tb_sound_player.sv
// tb_sound_player: directed and random checks of sound_player against a cycle-index tone model
module tb_sound_player;
  localparam int HP = 3, HO = 5, HG = 2, DUR = 20, GAP = 4;
  localparam logic [1:0] STOP = 2'b00, PING = 2'b10, PONG = 2'b01, GO = 2'b11;
  logic clk = 1'b0, clr = 1'b1, play = 1'b0, mute = 1'b0;
  logic [1:0] code_sound = 2'b00;
  logic speaker, busy;
  int checks = 0, failures = 0;
  bit m_act = 1'b0;
  logic [1:0] m_code = 2'b00;
  int m_s = 0;
  logic m_spk = 1'b0;
  int tog = 0, bcnt = 0;
  logic prev_spk = 1'b0;
  always #5 clk = ~clk;
  sound_player #(
    .CNT_W(24), .HALF_PING(HP), .HALF_PONG(HO), .HALF_GO(HG), .DUR_CYC(DUR), .GAP_CYC(GAP)
  ) dut (
    .clk(clk), .clr(clr), .play(play), .code_sound(code_sound),
    .mute(mute), .speaker(speaker), .busy(busy)
  );
  // phase of a request s cycles after its play edge: 0 idle, 1 first note, 2 gap, 3 second note
  function automatic int ph(input logic [1:0] c, input int s);
    if (s < DUR) return 1;
    if (c != GO) return 0;
    if (s < DUR + GAP) return 2;
    if (s < 2 * DUR + GAP) return 3;
    return 0;
  endfunction
  function automatic logic tn(input logic [1:0] c, input int s);
    int p, h;
    p = ph(c, s);
    h = c == PING ? HP : c == PONG ? HO : HG;
    if (p == 1) return logic'((s / h) % 2);
    if (p == 3) return logic'(((s - DUR - GAP) / HO) % 2);
    return 1'b0;
  endfunction
  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic p, input logic [1:0] c, input logic m);
    int p0, p1;
    play = p;
    code_sound = c;
    mute = m;
    @(posedge clk);
    if (p) begin
      m_spk = 1'b0;
      if (c == STOP) m_act = 1'b0;
      else begin
        m_act = 1'b1;
        m_code = c;
        m_s = 0;
      end
    end else if (m_act) begin
      p0 = ph(m_code, m_s);
      p1 = ph(m_code, m_s + 1);
      m_spk = (p1 != 0 && p1 == p0 && p1 != 2) ? (tn(m_code, m_s) & ~m) : 1'b0;
      m_s++;
      if (p1 == 0) m_act = 1'b0;
    end else m_spk = 1'b0;
    #1;
    chk("busy", busy, m_act);
    chk("speaker", speaker, m_spk);
    if (speaker !== prev_spk) tog++;
    prev_spk = speaker;
    if (busy) bcnt++;
    play = 1'b0;
  endtask
  initial begin
    logic mr;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_speaker", speaker, 1'b0);
    clr = 1'b0;
    tog = 0; bcnt = 0; prev_spk = speaker;
    cyc(1, PING, 0);
    repeat (24) cyc(0, STOP, 0);
    chk_i("ping_busy_len", bcnt, 20);
    chk_i("ping_toggles", tog, 6);
    bcnt = 0;
    cyc(1, GO, 0);
    repeat (50) cyc(0, STOP, 0);
    chk_i("go_busy_len", bcnt, 44);
    bcnt = 0;
    cyc(1, PING, 0);
    repeat (9) cyc(0, STOP, 0);
    cyc(1, PONG, 0);
    repeat (25) cyc(0, STOP, 0);
    chk_i("retrig_busy_len", bcnt, 30);
    bcnt = 0;
    cyc(1, PING, 0);
    for (int i = 1; i <= 24; i++) cyc(0, STOP, logic'(i >= 5 && i <= 15));
    chk_i("mute_busy_len", bcnt, 20);
    cyc(1, GO, 0);
    repeat (8) cyc(0, STOP, 0);
    cyc(1, STOP, 0);
    chk("stop_busy", busy, 1'b0);
    cyc(1, STOP, 0);
    chk("stop_idle_speaker", speaker, 1'b0);
    cyc(1, GO, 0);
    repeat (30) cyc(0, STOP, 0);
    chk("note2_busy", busy, 1'b1);
    #2 clr = 1'b1;
    #1;
    chk("clr_busy", busy, 1'b0);
    chk("clr_speaker", speaker, 1'b0);
    m_act = 1'b0;
    m_spk = 1'b0;
    @(negedge clk) clr = 1'b0;
    tog = 0; bcnt = 0; prev_spk = speaker;
    cyc(1, PING, 0);
    repeat (24) cyc(0, STOP, 0);
    chk_i("post_clr_busy_len", bcnt, 20);
    chk_i("post_clr_toggles", tog, 6);
    mr = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(9) == 0) mr = ~mr;
      if ($urandom_range(24) == 0) cyc(1, 2'($urandom_range(3)), mr);
      else cyc(0, 2'($urandom_range(3)), mr);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
